ddc_hb_decim_cascade: RTL and testbench
=======================================

# ddc_hb_decim_cascade

Two-stage half-band decimate-by-2 cascade for complex I/Q baseband, giving an overall decimate-by-4. It sits in the downconverter receive path after the mixer/NCO and before the channel filter. It is the receive-side counterpart of the upconverter half-band interpolator cascade. The input is push-only: the ADC-side path cannot be stalled, so there is no backpressure in either direction.

## Interface
- `WIDTH`, 16, signed sample width of each of I and Q (input and output).
- `i_clock` input 1 — sole clock.
- `i_reset` input 1 — synchronous, active-high reset.
- `i_inph_data` input WIDTH — signed in-phase sample.
- `i_quad_data` input WIDTH — signed quadrature sample.
- `i_valid` input 1 — sample present this cycle; may be high every cycle.
- `o_inph_data` output WIDTH — signed decimated in-phase sample.
- `o_quad_data` output WIDTH — signed decimated quadrature sample.
- `o_valid` output 1 — single-cycle pulse per decimated output sample.

## Operation
- Two identical stages, S1 then S2; S2's input is S1's registered output and valid. I and Q are processed identically in parallel and share one valid and phase.
- Each stage has a 7-tap half-band filter h = [-1, 0, 9, 16, 9, 0, -1], with gain 32, normalised by shifting right by 5.
- Each stage has a 7-deep delay line x[n..n-6] per rail. It shifts only on an accepted input sample (stage valid high). There is no shift otherwise.
- Each stage has a 1-bit phase toggle, which is 0 after reset and flips on every accepted sample.
  - An output is computed when the accepted sample arrives with phase = 1, i.e. on the 2nd, 4th, 6th … sample since reset.
  - The output uses the delay line including the new sample: y = Σ h[k]·x[n-k].
- Arithmetic:
  - Signed accumulator of WIDTH+6 bits.
  - Zero taps are not multiplied.
  - Symmetric pairs are pre-added.
  - Round half-up: (acc + 16) >>> 5.
  - Saturation is per the Configuration section.
- Output data registers hold their last value between `o_valid` pulses.
- Reset, including mid-stream, does the following:
  - Clears all delay lines and both phases to 0.
  - Sets `o_valid` = 0, `o_inph_data` = 0 and `o_quad_data` = 0.
  - `i_valid` during reset is ignored.
  - In-flight partial results are discarded.
  - The first sample after reset is phase 0 again.
- Gaps in `i_valid` are arbitrary. Filter state and phase are preserved across gaps.

## Timing
- S1 registers its output on the clock edge that accepts its phase-1 sample, so the S1 valid is high in the following cycle. S2 behaves the same way.
- A sample presented with `i_valid` in cycle t that completes an S2 pair produces `o_valid` high in cycle t+2. This is a fixed 2-cycle latency.
- The first final output follows the 4th input sample after reset. After that there is exactly one `o_valid` per 4 accepted inputs.
- `o_valid` is never high on two consecutive cycles. With `i_valid` held high continuously, `o_valid` pulses every 4th cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `DDC_HB_SATURATE_EN` defined:
  - Each stage clamps its rounded result to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before registering.
- Not defined:
  - The rounded result is truncated to its low WIDTH bits, giving two's-complement wrap.
  - There is no clamp logic.

## Test plan
- Reset, then `i_valid` held high with I = Q = 1000 constant for 40 samples.
  - `o_valid` pulses every 4 cycles.
  - After S1/S2 settling, every output is I = Q = 1000.
- Odd-index impulse into S1: I = 16384 at sample index 1, zeros elsewhere, Q = 0.
  - S1 outputs are -512, 4608, 4608, -512, then 0.
  - S1 output is observable by a white-box probe.
- Even-index impulse: I = 16384 at index 0, zeros elsewhere. S1 emits a single nonzero output, 8192, at its 2nd output.
- Overflow: I samples 0, -32768, 0, 32767, 32767, 32767, 0, -32768 (the index-7 sample is an output phase).
  - With `DDC_HB_SATURATE_EN`, the S1 output is 0x7FFF.
  - Without it, the S1 output is 0x8FFF (-28673).
- Gapped input: `i_valid` asserted every 3rd cycle with the DC-1000 stream. Outputs are identical to the continuous case, with `o_valid` once per 4 accepted samples, 2 cycles after the 4th.
- Mid-stream reset: pulse `i_reset` for 1 cycle after input sample 6.
  - `o_valid`, I and Q read 0 in the next cycle.
  - The next `o_valid` follows the 4th post-reset sample, and its value reflects only post-reset data.

Source files
------------

// File: rtl/ddc_hb_decim_cascade.sv
// ddc_hb_decim_cascade
// Two cascaded half-band decimate-by-2 stages (S1 -> S2) for complex I/Q,
// giving an overall decimate-by-4 in the downconverter receive path.
// Push-only input: no backpressure anywhere.
//
// Each stage filters with h = [-1, 0, 9, 16, 9, 0, -1] (gain 32), rounds
// half-up with (acc + 16) >>> 5 and emits one sample for every second
// accepted input (the phase-1 sample). A stage registers its output on the
// edge that accepts its phase-1 sample, so input-to-o_valid latency is 2.
//
// Ports:
//   i_clock      - sole clock
//   i_reset      - synchronous active-high reset (clears filter state/outputs)
//   i_inph_data  - signed in-phase input sample   [WIDTH]
//   i_quad_data  - signed quadrature input sample [WIDTH]
//   i_valid      - input sample present this cycle
//   o_inph_data  - signed decimated in-phase output (held between pulses)
//   o_quad_data  - signed decimated quadrature output (held between pulses)
//   o_valid      - one-cycle pulse per decimated output sample
//
// Build option: define DDC_HB_SATURATE_EN to clamp each stage's rounded
// result to the WIDTH-bit signed range; otherwise the result wraps.
module ddc_hb_decim_cascade #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_inph_data,
  input  logic [WIDTH-1:0] i_quad_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_inph_data,
  output logic [WIDTH-1:0] o_quad_data,
  output logic             o_valid
);

  localparam int ACC_W = WIDTH + 6;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(16);

  // Stage boundary buses: index 0 is the cascade input, index gi+1 is the
  // registered output of stage gi. Second index is the rail (0 = I, 1 = Q).
  logic [2:0][1:0][WIDTH-1:0] stg_dat;
  logic [2:0]                 stg_vld;

  assign stg_dat[0][0] = i_inph_data;
  assign stg_dat[0][1] = i_quad_data;
  assign stg_vld[0]    = i_valid;

  function automatic logic signed [ACC_W-1:0] sx(input logic signed [WIDTH-1:0] v);
    return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  genvar gi, gk;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stage
      logic phase_q;
      logic vld_q;

      // I and Q share one phase; a stage fires on its phase-1 sample.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          phase_q <= 1'b0;
          vld_q   <= 1'b0;
        end else begin
          vld_q <= stg_vld[gi] & phase_q;
          if (stg_vld[gi]) begin
            phase_q <= ~phase_q;
          end
        end
      end

      assign stg_vld[gi+1] = vld_q;

      for (gk = 0; gk < 2; gk++) begin : g_rail
        logic signed [WIDTH-1:0] x_in;
        // hist_q[k] holds x[n-1-k] relative to the sample now on x_in, so
        // together with x_in it forms the 7-deep window x[n..n-6].
        logic signed [WIDTH-1:0] hist_q [6];
        logic signed [WIDTH-1:0] y_q;
        logic signed [WIDTH-1:0] y_d;
        logic signed [ACC_W-1:0] pair_outer;
        logic signed [ACC_W-1:0] pair_inner;
        logic signed [ACC_W-1:0] acc;
`ifdef DDC_HB_SATURATE_EN
        localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (WIDTH - 1)) - 1);
        localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);
        logic signed [ACC_W-1:0] rnd;
`endif

        assign x_in = stg_dat[gi][gk];

        always_comb begin
          // Symmetric taps pre-added; x9 and x16 done as shift-adds.
          pair_outer = sx(x_in) + sx(hist_q[5]);
          pair_inner = sx(hist_q[1]) + sx(hist_q[3]);
          acc = (pair_inner <<< 3) + pair_inner + (sx(hist_q[2]) <<< 4) - pair_outer;
`ifdef DDC_HB_SATURATE_EN
          rnd = (acc + RND) >>> 5;
          if (rnd > SAT_HI) begin
            y_d = SAT_HI[WIDTH-1:0];
          end else if (rnd < SAT_LO) begin
            y_d = SAT_LO[WIDTH-1:0];
          end else begin
            y_d = rnd[WIDTH-1:0];
          end
`else
          // Keep only the low WIDTH bits: two's-complement wrap on overflow.
          y_d = WIDTH'((acc + RND) >>> 5);
`endif
        end

        always_ff @(posedge i_clock) begin
          if (i_reset) begin
            for (int k = 0; k < 6; k++) begin
              hist_q[k] <= '0;
            end
            y_q <= '0;
          end else if (stg_vld[gi]) begin
            hist_q[0] <= x_in;
            for (int k = 1; k < 6; k++) begin
              hist_q[k] <= hist_q[k-1];
            end
            if (phase_q) begin
              y_q <= y_d;
            end
          end
        end

        assign stg_dat[gi+1][gk] = y_q;
      end
    end
  endgenerate

  assign o_inph_data = stg_dat[2][0];
  assign o_quad_data = stg_dat[2][1];
  assign o_valid     = stg_vld[2];

endmodule

// File: tb/tb_ddc_hb_decim_cascade.sv
// Bench for ddc_hb_decim_cascade: a sample-sequence model of the two
// half-band decimators (plain convolution over the last 7 accepted samples)
// predicts every o_valid/o_inph_data/o_quad_data cycle, and a few literal
// values pin the model and the S1 intermediate results.
module tb_ddc_hb_decim_cascade;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                i_reset = 1'b0;
  logic                i_valid = 1'b0;
  logic [W-1:0]        i_inph_data = '0;
  logic [W-1:0]        i_quad_data = '0;
  logic signed [W-1:0] o_inph_data;
  logic signed [W-1:0] o_quad_data;
  logic                o_valid;

  ddc_hb_decim_cascade #(.WIDTH(W)) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_inph_data(i_inph_data),
    .i_quad_data(i_quad_data),
    .i_valid    (i_valid),
    .o_inph_data(o_inph_data),
    .o_quad_data(o_quad_data),
    .o_valid    (o_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; int i; int q; } exp_t;
  exp_t exp_q[$];

  localparam int H [7] = '{-1, 0, 9, 16, 9, 0, -1};
  int win [2][2][7];   // [stage][rail][age], age 0 = newest
  bit ph [2];
  int cyc = 0;

  function automatic int fix(input int y);
`ifdef DDC_HB_SATURATE_EN
    if (y > 32767) return 32767;
    if (y < -32768) return -32768;
    return y;
`else
    shortint s;
    s = shortint'(y);
    return int'(s);
`endif
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      ph[s] = 1'b0;
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 7; k++) win[s][r][k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_stage(input int st, input int xi, input int xq,
                             output bit prod, output int yi, output int yq);
    int xs [2];
    int ys [2];
    int acc;
    xs[0] = xi;
    xs[1] = xq;
    for (int r = 0; r < 2; r++) begin
      for (int k = 6; k > 0; k--) win[st][r][k] = win[st][r][k-1];
      win[st][r][0] = xs[r];
      acc = 0;
      for (int k = 0; k < 7; k++) acc += H[k] * win[st][r][k];
      ys[r] = fix((acc + 16) >>> 5);   // floor((acc+16)/32)
    end
    prod = ph[st];
    ph[st] = ~ph[st];
    yi = ys[0];
    yq = ys[1];
  endtask

  task automatic model_push(input int xi, input int xq);
    bit p1, p2;
    int a, b, c, d;
    model_stage(0, xi, xq, p1, a, b);
    if (p1) begin
      model_stage(1, a, b, p2, c, d);
      if (p2) exp_q.push_back('{due: cyc + 1, i: c, q: d});
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input int xi, input int xq, input bit rst);
    @(negedge clk);
    i_reset     = rst;
    i_valid     = v;
    i_inph_data = xi[W-1:0];
    i_quad_data = xq[W-1:0];
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else if (v) model_push(xi, xq);
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  int held_i = 0, held_q = 0;
  int out_count = 0;
  int last_i = 0, last_q = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (i_reset === 1'b0 && exp_q.size() == 0 && cyc == -1) begin
        // unreachable guard kept out; no-op
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("o_valid", int'(o_valid), 1);
        check("o_inph_data", int'(o_inph_data), e.i);
        check("o_quad_data", int'(o_quad_data), e.q);
        held_i = e.i;
        held_q = e.q;
        out_count++;
        last_i = int'(o_inph_data);
        last_q = int'(o_quad_data);
      end else begin
        check("o_valid_idle", int'(o_valid), 0);
        check("o_inph_hold", int'(o_inph_data), held_i);
        check("o_quad_hold", int'(o_quad_data), held_q);
      end
    end
  end

  // S1 rail-I white-box capture
  int s1_cap[$];
  always @(negedge clk) begin
    if (chk_en && dut.g_stage[0].vld_q) s1_cap.push_back(int'(dut.g_stage[0].g_rail[0].y_q));
  end

  task automatic do_reset();
    step(1'b1, 1111, -2222, 1'b1);  // i_valid during reset must be ignored
    held_i = 0;
    held_q = 0;
    out_count = 0;
    s1_cap.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_s1(input string name, input int idx, input int exp);
    check(name, (s1_cap.size() > idx) ? s1_cap[idx] : 99999, exp);
  endtask

  int odd_exp [6] = '{-512, 4608, 4608, -512, 0, 0};
  int ovf_in  [8] = '{0, -32768, 0, 32767, 32767, 32767, 0, -32768};
  int ovf_exp;

  initial begin
`ifdef DDC_HB_SATURATE_EN
    ovf_exp = 32767;
`else
    ovf_exp = -28673;
`endif
    model_reset();
    step(1'b1, 5, 5, 1'b1);
    chk_en = 1'b1;
    do_reset();
    check("reset_o_valid", int'(o_valid), 0);
    check("reset_o_inph", int'(o_inph_data), 0);
    check("reset_o_quad", int'(o_quad_data), 0);

    // DC 1000, continuous
    for (int k = 0; k < 40; k++) step(1'b1, 1000, 1000, 1'b0);
    idle(4);
    check("dc_pulses", out_count, 10);
    check("dc_last_i", last_i, 1000);
    check("dc_last_q", last_q, 1000);

    // odd-index impulse
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b1, (k == 1) ? 16384 : 0, 0, 1'b0);
    idle(4);
    for (int k = 0; k < 6; k++) check_s1("s1_odd_impulse", k, odd_exp[k]);

    // even-index impulse
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, (k == 0) ? 16384 : 0, 0, 1'b0);
    idle(4);
    check_s1("s1_even_impulse0", 0, 0);
    check_s1("s1_even_impulse1", 1, 8192);
    check_s1("s1_even_impulse2", 2, 0);

    // overflow
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, ovf_in[k], ovf_in[k], 1'b0);
    idle(4);
    check_s1("s1_overflow", 3, ovf_exp);

    // gapped DC, valid every 3rd cycle
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1000, 1000, 1'b0);
      idle(2);
    end
    idle(3);
    check("gap_pulses", out_count, 10);
    check("gap_last_i", last_i, 1000);
    check("gap_last_q", last_q, 1000);

    // mid-stream reset
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 2000, -3000, 1'b0);
    do_reset();
    @(negedge clk);
    check("midrst_o_valid", int'(o_valid), 0);
    check("midrst_o_inph", int'(o_inph_data), 0);
    check("midrst_o_quad", int'(o_quad_data), 0);
    for (int k = 0; k < 4; k++) step(1'b1, 500, -500, 1'b0);
    idle(3);
    check("midrst_pulses", out_count, 1);
    check("midrst_first_i", last_i, -12);
    check("midrst_first_q", last_q, 12);

    idle(2);
    check("model_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
